seven_seg_scan_decoder: RTL

//   Receive-side counterpart of the two-digit multiplexed seven-segment driver. Watches the shared

---
 rtl/seven_seg_scan_decoder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - decodes a scanned two-digit seven-segment bus back into a byte
module seven_seg_scan_decoder #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int STABLE_FRAMES  = 3,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       clk_16mhz,
   input  logic       rst,
   input  logic [6:0] seg_in,
   input  logic       ca_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       byte_update,
   output logic       pattern_err,
   output logic       link_lost
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int FW = $clog2(STABLE_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

   // {valid, nibble}; blank and every non-hex pattern decode as invalid
   function automatic logic [4:0] decode_glyph(input logic [6:0] g);
      case (g)
         7'h3F: decode_glyph = 5'h10;
         7'h06: decode_glyph = 5'h11;
         7'h5B: decode_glyph = 5'h12;
         7'h4F: decode_glyph = 5'h13;
         7'h66: decode_glyph = 5'h14;
         7'h6D: decode_glyph = 5'h15;
         7'h7D: decode_glyph = 5'h16;
         7'h07: decode_glyph = 5'h17;
         7'h7F: decode_glyph = 5'h18;
         7'h6F: decode_glyph = 5'h19;
         7'h77: decode_glyph = 5'h1A;
         7'h7C: decode_glyph = 5'h1B;
         7'h39: decode_glyph = 5'h1C;
         7'h5E: decode_glyph = 5'h1D;
         7'h79: decode_glyph = 5'h1E;
         7'h71: decode_glyph = 5'h1F;
         default: decode_glyph = 5'h00;
      endcase
   endfunction

   logic [6:0]    seg_s1_q, seg_s2_q;
   logic          ca_s1_q, ca_s2_q, ca_dly_q;
   logic          ca_edge;
   state_t        state_q, state_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          timeout_hit;
   logic          link_lost_q, link_lost_d;
   logic          sample_en;
   logic [3:0]    cand_q [2];
   logic [3:0]    cand_d [2];
   logic [FW-1:0] cnt_q [2];
   logic [FW-1:0] cnt_d [2];
   logic [FW-1:0] cur_cnt;
   logic [1:0]    commit_q, commit_d;
   logic [7:0]    byte_q, byte_d;
   logic          upd_q, upd_d, perr_q, perr_d;
   logic [4:0]    dec;
   logic          dig;

   assign ca_edge     = ca_s2_q ^ ca_dly_q;
   assign dig         = ca_s2_q;
   assign dec         = decode_glyph(seg_s2_q);
   assign timeout_hit = !ca_edge && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   // two-flop synchronizers for the asynchronous bus plus the ca delay used for edge detection
   always_ff @(posedge clk_16mhz or posedge rst) begin
      if (rst) begin
         seg_s1_q <= '0;
         seg_s2_q <= '0;
         ca_s1_q  <= 1'b0;
         ca_s2_q  <= 1'b0;
         ca_dly_q <= 1'b0;
      end else begin
         seg_s1_q <= seg_in;
         seg_s2_q <= seg_s1_q;
         ca_s1_q  <= ca_in;
         ca_s2_q  <= ca_s1_q;
         ca_dly_q <= ca_s2_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk_16mhz or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: any ca edge restarts settling, a timeout drops back to idle
   always_comb begin
      state_d = state_q;
      if (ca_edge) begin
         state_d = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
      end else if (timeout_hit) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_SETTLE: if (settle_cnt_q >= SW'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_HOLD;
            default:   state_d = state_q;
         endcase
      end
   end

   // FSM output: sample only when the digit select has not moved again this cycle
   always_comb begin
      sample_en = 1'b0;
      if (state_q == ST_SAMPLE && !ca_edge) sample_en = 1'b1;
   end

   // settle counter counts the edge cycle as 1 so sampling lands SETTLE_CYCLES after the edge
   always_comb begin
      settle_cnt_d = settle_cnt_q;
      if (ca_edge)                   settle_cnt_d = SW'(1);
      else if (state_q == ST_SETTLE) settle_cnt_d = settle_cnt_q + SW'(1);
   end

   // link supervision: count cycles since the last ca edge, saturating at the timeout
   always_comb begin
      link_lost_d = link_lost_q;
      tcnt_d      = tcnt_q;
      if (ca_edge) begin
         tcnt_d      = TW'(1);
         link_lost_d = 1'b0;
      end else if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
         tcnt_d = tcnt_q + TW'(1);
         if (timeout_hit) link_lost_d = 1'b1;
      end
   end

   // per-digit debounce of decoded glyphs and commit into the output byte
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      commit_d = commit_q;
      byte_d   = byte_q;
      upd_d    = 1'b0;
      perr_d   = 1'b0;
      cur_cnt  = '0;
      if (timeout_hit) begin
         cnt_d[0] = '0;
         cnt_d[1] = '0;
         commit_d = 2'b00;
      end else if (sample_en) begin
         if (!dec[4]) begin
            perr_d     = 1'b1;
            cnt_d[dig] = '0;
         end else begin
            if (dec[3:0] == cand_q[dig]) begin
               cur_cnt = (cnt_q[dig] == FW'(STABLE_FRAMES)) ? cnt_q[dig] : cnt_q[dig] + FW'(1);
            end else begin
               cur_cnt     = FW'(1);
               cand_d[dig] = dec[3:0];
            end
            cnt_d[dig] = cur_cnt;
            if (cur_cnt == FW'(STABLE_FRAMES)) begin
               commit_d[dig] = 1'b1;
               if (dig) byte_d[7:4] = dec[3:0];
               else     byte_d[3:0] = dec[3:0];
               upd_d = (byte_d != byte_q) && (&commit_d);
            end
         end
      end
   end

   // datapath registers
   always_ff @(posedge clk_16mhz or posedge rst) begin
      if (rst) begin
         settle_cnt_q <= '0;
         tcnt_q       <= TW'(TIMEOUT_CYCLES);
         link_lost_q  <= 1'b1;
         cand_q[0]    <= '0;
         cand_q[1]    <= '0;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
         commit_q     <= 2'b00;
         byte_q       <= 8'h00;
         upd_q        <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         settle_cnt_q <= settle_cnt_d;
         tcnt_q       <= tcnt_d;
         link_lost_q  <= link_lost_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         commit_q     <= commit_d;
         byte_q       <= byte_d;
         upd_q        <= upd_d;
         perr_q       <= perr_d;
      end
   end

   assign byte_out    = byte_q;
   assign byte_valid  = (&commit_q) & ~link_lost_q;
   assign byte_update = upd_q;
   assign pattern_err = perr_q;
   assign link_lost   = link_lost_q;

endmodule
